// File: rtl/loop_filter_seq_if.sv
// Detector strobes in, loop-filter controls out.
// The master modport drives the detector side.
`timescale 1ns/1ps
interface loop_filter_seq_if #(
  parameter int FreqGainWidth  = 5,
  parameter int PhaseGainWidth = 5
);
  logic                      start;
  logic                      fd_valid;
  logic                      fd_sign;
  logic                      pd_valid;
  logic                      pd_sign;
  logic                      freq_incr_decr;
  logic [FreqGainWidth-1:0]  freq_gain_adj;
  logic [PhaseGainWidth-1:0] phase_gain_adj;
  logic                      phase_updn;
  logic                      filter_step;
  logic                      locked;
  logic                      timeout_err;

  modport master (
    output start, fd_valid, fd_sign,
    output pd_valid, pd_sign,
    input  freq_incr_decr, freq_gain_adj,
    input  phase_gain_adj, phase_updn,
    input  filter_step, locked, timeout_err
  );

  modport slave (
    input  start, fd_valid, fd_sign,
    input  pd_valid, pd_sign,
    output freq_incr_decr, freq_gain_adj,
    output phase_gain_adj, phase_updn,
    output filter_step, locked, timeout_err
  );
endinterface

// File: rtl/loop_filter_seq.sv
// Acquisition sequencer: coarse frequency search with gain halving,
// then phase tracking with lock detection and slip recovery.
`timescale 1ns/1ps
module loop_filter_seq #(
  parameter int FreqGainWidth  = 5,
  parameter int PhaseGainWidth = 5,
  parameter int CoarseGain     = 16,
  parameter int MinGain        = 1,
  parameter int PhaseGain      = 4,
  parameter int LockCount      = 16,
  parameter int SlipCount      = 8,
  parameter int TimeoutCycles  = 1023
) (
  input logic filter_clock,
  input logic reset,
  loop_filter_seq_if.slave bus
);
  localparam int FW = FreqGainWidth;
  localparam int PW = PhaseGainWidth;
  localparam int TW = $clog2(TimeoutCycles + 1);
  localparam int LW = $clog2(LockCount + 1);
  localparam int SW = $clog2(SlipCount + 1);

  localparam logic [FW-1:0] COARSE_G = FW'(CoarseGain);
  localparam logic [FW-1:0] MIN_G    = FW'(MinGain);
  localparam logic [PW-1:0] PHASE_G  = PW'(PhaseGain);
  localparam logic [TW-1:0] WD_LAST  = TW'(TimeoutCycles - 1);
  localparam logic [LW-1:0] LOCK_N   = LW'(LockCount);
  localparam logic [LW-1:0] LOCK_M1  = LW'(LockCount - 1);
  localparam logic [SW-1:0] SLIP_M1  = SW'(SlipCount - 1);

  typedef enum logic [2:0] {
    IDLE, COARSE, TRACK, LOCKED, ERROR
  } state_e;

  state_e        state_q;
  logic          dir_q;
  logic          updn_q;
  logic          step_q;
  logic [FW-1:0] fgain_q;
  logic [PW-1:0] pgain_q;
  logic [TW-1:0] wdog_q;
  logic          fd_seen_q;
  logic          fd_prev_q;
  logic          pd_seen_q;
  logic          pd_prev_q;
  logic [LW-1:0] alt_q;
  logic [SW-1:0] run_q;

  logic [FW-1:0] half_d;
  logic          fd_rev_d;
  logic          pd_same_d;

  always_comb begin
    half_d = fgain_q >> 1;
    if (half_d < MIN_G) half_d = MIN_G;
  end

  assign fd_rev_d  = fd_seen_q && (bus.fd_sign != fd_prev_q);
  assign pd_same_d = pd_seen_q && (bus.pd_sign == pd_prev_q);

  always_ff @(posedge filter_clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      dir_q     <= 1'b0;
      updn_q    <= 1'b0;
      step_q    <= 1'b0;
      fgain_q   <= '0;
      pgain_q   <= '0;
      wdog_q    <= '0;
      fd_seen_q <= 1'b0;
      fd_prev_q <= 1'b0;
      pd_seen_q <= 1'b0;
      pd_prev_q <= 1'b0;
      alt_q     <= '0;
      run_q     <= '0;
    end else begin
      step_q <= 1'b0;
      if (!bus.start) begin
        state_q <= IDLE;
        dir_q   <= 1'b0;
        updn_q  <= 1'b0;
        fgain_q <= '0;
        pgain_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q   <= COARSE;
            fgain_q   <= COARSE_G;
            pgain_q   <= '0;
            wdog_q    <= '0;
            fd_seen_q <= 1'b0;
            pd_seen_q <= 1'b0;
            alt_q     <= '0;
            run_q     <= '0;
          end
          COARSE: begin
            if (wdog_q == WD_LAST) begin
              state_q <= ERROR;
              fgain_q <= '0;
              pgain_q <= '0;
            end else begin
              wdog_q <= wdog_q + TW'(1);
              if (bus.fd_valid) begin
                dir_q     <= bus.fd_sign;
                step_q    <= 1'b1;
                fd_seen_q <= 1'b1;
                fd_prev_q <= bus.fd_sign;
                if (fd_rev_d) begin
                  if (fgain_q == MIN_G) begin
                    state_q   <= TRACK;
                    pgain_q   <= PHASE_G;
                    pd_seen_q <= 1'b0;
                    alt_q     <= '0;
                    run_q     <= '0;
                  end else begin
                    fgain_q <= half_d;
                  end
                end
              end
            end
          end
          TRACK, LOCKED: begin
            if (bus.pd_valid) begin
              updn_q    <= bus.pd_sign;
              step_q    <= 1'b1;
              pd_seen_q <= 1'b1;
              pd_prev_q <= bus.pd_sign;
              if (pd_same_d) begin
                alt_q <= '0;
                // long same-sign run: phase slipped, restart search
                if (run_q == SLIP_M1) begin
                  state_q   <= COARSE;
                  fgain_q   <= COARSE_G;
                  pgain_q   <= '0;
                  wdog_q    <= '0;
                  fd_seen_q <= 1'b0;
                  pd_seen_q <= 1'b0;
                  run_q     <= '0;
                end else begin
                  run_q <= run_q + SW'(1);
                end
              end else begin
                run_q <= SW'(1);
                if (alt_q != LOCK_N) alt_q <= alt_q + LW'(1);
                if (alt_q == LOCK_M1) state_q <= LOCKED;
              end
            end
          end
          ERROR: ;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.freq_incr_decr = dir_q;
  assign bus.freq_gain_adj  = fgain_q;
  assign bus.phase_gain_adj = pgain_q;
  assign bus.phase_updn     = updn_q;
  assign bus.filter_step    = step_q;
  assign bus.locked         = (state_q == LOCKED);
  assign bus.timeout_err    = (state_q == ERROR);
endmodule
